fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  IF stage of the 8-bit 4-register pipeline. Owns the PC and the boot-vector load. Assembles
//  one-/two-byte instructions from the byte-wide instruction memory and drives the IF/ID pipeline
//  register. Consumes pc_en / if_id_en / flush / branch target from the hazard unit and EX; feeds
//  ra/rb back to the hazard unit.
// PARAMETERS
//  ADDR_W    8      PC / instruction-memory address width
//  LONG_OPC  4'hC   opcode (instr[7:4]) that marks a two-byte instruction (opcode + imm byte)
//  BOOT_ADDR 8'h00  address holding the reset vector
// PORTS
//  clk            in   1       rising-edge clock, single domain
//  rst            in   1       synchronous, active-high reset
//  pc_en          in   1       0 = freeze PC and FSM (load-use stall)
//  if_id_en       in   1       0 = freeze IF/ID outputs
//  flush          in   1       branch taken: redirect and kill in-flight fetch
//  branch_target  in   ADDR_W  PC to load on flush
//  imem_addr      out  ADDR_W  = pc; combinational read address
//  imem_data      in   8       byte at imem_addr, same cycle (async ROM)
//  if_id_instr    out  8       registered opcode byte
//  if_id_imm      out  8       registered immediate (0 for one-byte instr)
//  if_id_pc_next  out  ADDR_W  registered address after the instruction (CALL return)
//  if_id_valid    out  1       registered; 0 = bubble
//  if_id_ra       out  2       if_id_instr[3:2], to hazard unit
//  if_id_rb       out  2       if_id_instr[1:0], to hazard unit
// BEHAVIOUR
//  - Reset: state=BOOT, pc=BOOT_ADDR, hold=0; all if_id_* = 0. rst overrides everything, any state.
//  - FSM states: BOOT, OP, IMM.
//    BOOT: pc <= imem_data (vector), -> OP; if_id_valid=0. Takes exactly 1 cycle; ignores flush/stall.
//    OP: if imem_data[7:4]==LONG_OPC: hold<=imem_data, pc<=pc+1, -> IMM, IF/ID loads bubble.
//        Else: IF/ID <= {instr=imem_data, imm=0, pc_next=pc+1, valid=1}, pc<=pc+1, stay OP.
//    IMM: IF/ID <= {instr=hold, imm=imem_data, pc_next=pc+1, valid=1}, pc<=pc+1, -> OP.
//  - Priority (OP/IMM): rst > flush > stall > advance.
//  - flush=1: pc<=branch_target, state->OP, hold discarded, if_id_valid<=0 (other if_id_* don't care),
//    regardless of pc_en/if_id_en. Target fetched next cycle.
//  - stall = ~pc_en | ~if_id_en: pc, state, hold and all if_id_* hold their value. An
//    instruction split across OP/IMM resumes correctly after any stall length.
//  - PC arithmetic mod 2^ADDR_W: 8'hFF+1 = 8'h00; a long opcode at 8'hFF takes its imm from 8'h00.
//  - Latency: one-byte instr visible on if_id_* 1 cycle after its address on imem_addr. Two-byte:
//    2 cycles after the opcode address, preceded by exactly one bubble.
//  - Throughput: 1 instr/cycle (one-byte), 1 per 2 cycles (two-byte), absent stall/flush.
//  - No combinational path from imem_data to any if_id_* output.
// STRUCTURE
//  - Shared pkg/header: opcode field positions, LONG_OPC, BOOT_ADDR, FSM state encodings
//    (also used by decode).
//  - One sub-module natural: if_id_reg (instr/imm/pc_next/valid with en + flush). PC/FSM in top.
// TESTING
//  1 rst 2 cycles, imem[00]=8'h10 -> cycle after rst: imem_addr=00; next: imem_addr=10, valid=0.
//  2 imem[10..12]=8'h21,8'h35,8'h4A -> valid 3 consecutive cycles; pc_next=11,12,13; ra/rb of 8'h35 = 1/1.
//  3 imem[10]=8'hC4, imem[11]=8'h5A -> one bubble, then instr=C4, imm=5A, pc_next=12, valid=1.
//  4 pc_en=if_id_en=0 for 3 cycles while in IMM -> all outputs/imem_addr frozen; release ->
//    {C4,5A} emitted once.
//  5 flush=1, branch_target=8'h40, in IMM with pc_en=0 -> next cycle imem_addr=40, valid=0, no C4 emitted.
//  6 Long opcode at 8'hFF, imem[00]=8'h77 -> instr/imm = {C?,77}, pc_next=01; rst asserted mid-IMM -> BOOT.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared fetch/decode definitions: instruction field positions, long-opcode marker,
// boot vector address and the fetch FSM state encoding.
package fetch_stage_pkg;

  localparam int OPC_HI = 7;
  localparam int OPC_LO = 4;
  localparam int RA_HI  = 3;
  localparam int RA_LO  = 2;
  localparam int RB_HI  = 1;
  localparam int RB_LO  = 0;

  localparam logic [3:0] LONG_OPC_DEF  = 4'hC;
  localparam logic [7:0] BOOT_ADDR_DEF = 8'h00;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_OP   = 2'd1,
    ST_IMM  = 2'd2
  } fetch_state_e;

  function automatic logic is_long_opc(input logic [7:0] b, input logic [3:0] opc);
    return b[OPC_HI:OPC_LO] == opc;
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: loads on en, flush only kills valid, reset clears everything.
module fetch_stage_if_id_reg #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              flush_i,
  input  logic [7:0]        instr_i,
  input  logic [7:0]        imm_i,
  input  logic [ADDR_W-1:0] pc_next_i,
  input  logic              valid_i,
  output logic [7:0]        instr_o,
  output logic [7:0]        imm_o,
  output logic [ADDR_W-1:0] pc_next_o,
  output logic              valid_o
);

  logic [7:0]        instr_q;
  logic [7:0]        imm_q;
  logic [ADDR_W-1:0] pc_next_q;
  logic              valid_q;

  // Flush leaves the payload fields stale; only valid matters to downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q   <= '0;
      imm_q     <= '0;
      pc_next_q <= '0;
      valid_q   <= 1'b0;
    end else if (flush_i) begin
      valid_q   <= 1'b0;
    end else if (en_i) begin
      instr_q   <= instr_i;
      imm_q     <= imm_i;
      pc_next_q <= pc_next_i;
      valid_q   <= valid_i;
    end
  end

  assign instr_o   = instr_q;
  assign imm_o     = imm_q;
  assign pc_next_o = pc_next_q;
  assign valid_o   = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, loads the boot vector, assembles one-/two-byte instructions
// from the byte-wide async ROM and drives the IF/ID register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int                ADDR_W    = 8,
  parameter logic [3:0]        LONG_OPC  = LONG_OPC_DEF,
  parameter logic [ADDR_W-1:0] BOOT_ADDR = ADDR_W'(BOOT_ADDR_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_en,
  input  logic              if_id_en,
  input  logic              flush,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [7:0]        imem_data,
  output logic [7:0]        if_id_instr,
  output logic [7:0]        if_id_imm,
  output logic [ADDR_W-1:0] if_id_pc_next,
  output logic              if_id_valid,
  output logic [1:0]        if_id_ra,
  output logic [1:0]        if_id_rb,
  output fetch_state_e      state_dbg
);

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [7:0]        hold_q;

  logic              stall;
  logic              op_long;
  logic [ADDR_W-1:0] pc_inc;

  assign stall   = ~pc_en | ~if_id_en;
  assign op_long = is_long_opc(imem_data, LONG_OPC);
  assign pc_inc  = pc_q + ADDR_W'(1);

  // Priority in OP/IMM: rst > flush > stall > advance. BOOT always completes in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_BOOT;
      pc_q    <= BOOT_ADDR;
      hold_q  <= '0;
    end else begin
      case (state_q)
        ST_BOOT: begin
          pc_q    <= ADDR_W'(imem_data);
          state_q <= ST_OP;
        end
        default: begin
          if (flush) begin
            pc_q    <= branch_target;
            state_q <= ST_OP;
            hold_q  <= '0;
          end else if (!stall) begin
            pc_q <= pc_inc;
            if (state_q == ST_IMM) begin
              state_q <= ST_OP;
            end else if (op_long) begin
              hold_q  <= imem_data;
              state_q <= ST_IMM;
            end else begin
              state_q <= ST_OP;
            end
          end
        end
      endcase
    end
  end

  logic              reg_en_d;
  logic              reg_flush_d;
  logic [7:0]        ld_instr_d;
  logic [7:0]        ld_imm_d;
  logic              ld_valid_d;

  // IF/ID load controls; a long opcode in OP loads a bubble.
  always_comb begin
    reg_en_d    = 1'b0;
    reg_flush_d = 1'b0;
    ld_instr_d  = imem_data;
    ld_imm_d    = '0;
    ld_valid_d  = 1'b0;
    case (state_q)
      ST_BOOT: reg_en_d = 1'b1;
      default: begin
        if (flush) begin
          reg_flush_d = 1'b1;
        end else if (!stall) begin
          reg_en_d = 1'b1;
          if (state_q == ST_IMM) begin
            ld_instr_d = hold_q;
            ld_imm_d   = imem_data;
            ld_valid_d = 1'b1;
          end else begin
            ld_valid_d = ~op_long;
          end
        end
      end
    endcase
  end

  fetch_stage_if_id_reg #(.ADDR_W(ADDR_W)) u_if_id_reg (
    .clk       (clk),
    .rst       (rst),
    .en_i      (reg_en_d),
    .flush_i   (reg_flush_d),
    .instr_i   (ld_instr_d),
    .imm_i     (ld_imm_d),
    .pc_next_i (pc_inc),
    .valid_i   (ld_valid_d),
    .instr_o   (if_id_instr),
    .imm_o     (if_id_imm),
    .pc_next_o (if_id_pc_next),
    .valid_o   (if_id_valid)
  );

  assign imem_addr = pc_q;
  assign if_id_ra  = if_id_instr[RA_HI:RA_LO];
  assign if_id_rb  = if_id_instr[RB_HI:RB_LO];
  assign state_dbg = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: boot, one-/two-byte fetch, stall, flush, PC wrap, reset mid-IMM.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pc_en = 1'b1;
  logic       if_id_en = 1'b1;
  logic       flush = 1'b0;
  logic [7:0] branch_target = 8'h00;
  logic [7:0] imem_addr;
  logic [7:0] imem_data;
  logic [7:0] if_id_instr;
  logic [7:0] if_id_imm;
  logic [7:0] if_id_pc_next;
  logic       if_id_valid;
  logic [1:0] if_id_ra;
  logic [1:0] if_id_rb;
  fetch_state_e state_dbg;

  logic [7:0] mem [256];
  int checks = 0;
  int failures = 0;

  assign imem_data = mem[imem_addr];

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .pc_en         (pc_en),
    .if_id_en      (if_id_en),
    .flush         (flush),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .if_id_instr   (if_id_instr),
    .if_id_imm     (if_id_imm),
    .if_id_pc_next (if_id_pc_next),
    .if_id_valid   (if_id_valid),
    .if_id_ra      (if_id_ra),
    .if_id_rb      (if_id_rb),
    .state_dbg     (state_dbg)
  );

  // Outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  // Reset for two cycles, then run the BOOT cycle; leaves the FSM in OP at the vector.
  task automatic reset_and_boot();
    rst = 1'b1; pc_en = 1'b1; if_id_en = 1'b1; flush = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    clear_mem();
    mem[8'h00] = 8'h10;
    rst = 1'b1;
    tick(); tick();
    checks++;
    if ({imem_addr, if_id_instr, if_id_imm, if_id_pc_next, if_id_valid} !== {8'h00, 8'h00, 8'h00, 8'h00, 1'b0}) begin
      failures++;
      $display("FAIL reset_state: got addr=%h instr=%h imm=%h pcn=%h v=%b, want 00 00 00 00 0",
               imem_addr, if_id_instr, if_id_imm, if_id_pc_next, if_id_valid);
    end
    checks++;
    if (state_dbg !== ST_BOOT) begin
      failures++;
      $display("FAIL reset_fsm: got state=%0d, want %0d", state_dbg, ST_BOOT);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({imem_addr, if_id_valid} !== {8'h10, 1'b0}) begin
      failures++;
      $display("FAIL boot_vector: got addr=%h v=%b, want 10 0", imem_addr, if_id_valid);
    end
  endtask

  task automatic test_one_byte();
    logic [7:0] ins [3];
    ins[0] = 8'h21; ins[1] = 8'h35; ins[2] = 8'h4A;
    clear_mem();
    mem[8'h00] = 8'h10;
    for (int i = 0; i < 3; i++) mem[8'h10 + i] = ins[i];
    reset_and_boot();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({if_id_instr, if_id_imm, if_id_pc_next, if_id_valid, imem_addr} !==
          {ins[i], 8'h00, 8'(8'h11 + i), 1'b1, 8'(8'h11 + i)}) begin
        failures++;
        $display("FAIL one_byte[%0d]: got instr=%h imm=%h pcn=%h v=%b addr=%h, want %h 00 %h 1 %h",
                 i, if_id_instr, if_id_imm, if_id_pc_next, if_id_valid, imem_addr,
                 ins[i], 8'(8'h11 + i), 8'(8'h11 + i));
      end
      if (i == 1) begin
        checks++;
        if ({if_id_ra, if_id_rb} !== {2'd1, 2'd1}) begin
          failures++;
          $display("FAIL ra_rb: got ra=%0d rb=%0d, want 1 1", if_id_ra, if_id_rb);
        end
      end
    end
  endtask

  task automatic load_long_prog();
    clear_mem();
    mem[8'h00] = 8'h10;
    mem[8'h10] = 8'hC4;
    mem[8'h11] = 8'h5A;
    mem[8'h12] = 8'h21;
    mem[8'h40] = 8'h33;
  endtask

  task automatic test_long();
    load_long_prog();
    reset_and_boot();
    tick();
    checks++;
    if ({if_id_valid, imem_addr} !== {1'b0, 8'h11}) begin
      failures++;
      $display("FAIL long_bubble: got v=%b addr=%h, want 0 11", if_id_valid, imem_addr);
    end
    tick();
    checks++;
    if ({if_id_instr, if_id_imm, if_id_pc_next, if_id_valid} !== {8'hC4, 8'h5A, 8'h12, 1'b1}) begin
      failures++;
      $display("FAIL long_emit: got instr=%h imm=%h pcn=%h v=%b, want C4 5A 12 1",
               if_id_instr, if_id_imm, if_id_pc_next, if_id_valid);
    end
    tick();
    checks++;
    if ({if_id_instr, if_id_imm, if_id_pc_next, if_id_valid} !== {8'h21, 8'h00, 8'h13, 1'b1}) begin
      failures++;
      $display("FAIL long_follow: got instr=%h imm=%h pcn=%h v=%b, want 21 00 13 1",
               if_id_instr, if_id_imm, if_id_pc_next, if_id_valid);
    end
  endtask

  task automatic test_stall();
    logic en_pat [3][2];
    en_pat[0][0] = 1'b0; en_pat[0][1] = 1'b0;
    en_pat[1][0] = 1'b0; en_pat[1][1] = 1'b1;
    en_pat[2][0] = 1'b1; en_pat[2][1] = 1'b0;
    load_long_prog();
    reset_and_boot();
    tick();
    for (int i = 0; i < 3; i++) begin
      pc_en = en_pat[i][0];
      if_id_en = en_pat[i][1];
      tick();
      checks++;
      if ({imem_addr, if_id_valid} !== {8'h11, 1'b0}) begin
        failures++;
        $display("FAIL stall_imm[%0d]: got addr=%h v=%b, want 11 0", i, imem_addr, if_id_valid);
      end
    end
    pc_en = 1'b1; if_id_en = 1'b1;
    tick();
    checks++;
    if ({if_id_instr, if_id_imm, if_id_pc_next, if_id_valid} !== {8'hC4, 8'h5A, 8'h12, 1'b1}) begin
      failures++;
      $display("FAIL stall_release: got instr=%h imm=%h pcn=%h v=%b, want C4 5A 12 1",
               if_id_instr, if_id_imm, if_id_pc_next, if_id_valid);
    end
    tick();
    checks++;
    if ({if_id_instr, if_id_pc_next, if_id_valid} !== {8'h21, 8'h13, 1'b1}) begin
      failures++;
      $display("FAIL stall_once: got instr=%h pcn=%h v=%b, want 21 13 1",
               if_id_instr, if_id_pc_next, if_id_valid);
    end
    if_id_en = 1'b0;
    tick();
    checks++;
    if ({if_id_instr, if_id_pc_next, if_id_valid, imem_addr} !== {8'h21, 8'h13, 1'b1, 8'h13}) begin
      failures++;
      $display("FAIL stall_op_hold: got instr=%h pcn=%h v=%b addr=%h, want 21 13 1 13",
               if_id_instr, if_id_pc_next, if_id_valid, imem_addr);
    end
    if_id_en = 1'b1;
  endtask

  task automatic test_flush();
    load_long_prog();
    reset_and_boot();
    tick();
    pc_en = 1'b0;
    flush = 1'b1;
    branch_target = 8'h40;
    tick();
    checks++;
    if ({imem_addr, if_id_valid} !== {8'h40, 1'b0}) begin
      failures++;
      $display("FAIL flush_redirect: got addr=%h v=%b, want 40 0", imem_addr, if_id_valid);
    end
    flush = 1'b0;
    pc_en = 1'b1;
    tick();
    checks++;
    if ({if_id_instr, if_id_imm, if_id_pc_next, if_id_valid} !== {8'h33, 8'h00, 8'h41, 1'b1}) begin
      failures++;
      $display("FAIL flush_target: got instr=%h imm=%h pcn=%h v=%b, want 33 00 41 1",
               if_id_instr, if_id_imm, if_id_pc_next, if_id_valid);
    end
  endtask

  task automatic test_wrap_and_reset();
    clear_mem();
    mem[8'h00] = 8'h77;
    mem[8'hFF] = 8'hC7;
    reset_and_boot();
    flush = 1'b1;
    branch_target = 8'hFF;
    tick();
    flush = 1'b0;
    tick();
    checks++;
    if ({imem_addr, if_id_valid} !== {8'h00, 1'b0}) begin
      failures++;
      $display("FAIL wrap_addr: got addr=%h v=%b, want 00 0", imem_addr, if_id_valid);
    end
    tick();
    checks++;
    if ({if_id_instr, if_id_imm, if_id_pc_next, if_id_valid} !== {8'hC7, 8'h77, 8'h01, 1'b1}) begin
      failures++;
      $display("FAIL wrap_emit: got instr=%h imm=%h pcn=%h v=%b, want C7 77 01 1",
               if_id_instr, if_id_imm, if_id_pc_next, if_id_valid);
    end
    flush = 1'b1;
    branch_target = 8'hFF;
    tick();
    flush = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({imem_addr, if_id_valid, if_id_instr} !== {8'h00, 1'b0, 8'h00} || state_dbg !== ST_BOOT) begin
      failures++;
      $display("FAIL rst_mid_imm: got addr=%h v=%b instr=%h state=%0d, want 00 0 00 %0d",
               imem_addr, if_id_valid, if_id_instr, state_dbg, ST_BOOT);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({imem_addr, if_id_valid} !== {8'h77, 1'b0}) begin
      failures++;
      $display("FAIL reboot: got addr=%h v=%b, want 77 0", imem_addr, if_id_valid);
    end
  endtask

  initial begin
    test_reset();
    test_one_byte();
    test_long();
    test_stall();
    test_flush();
    test_wrap_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
